// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC bus responder: time register map,
// BCD roll-over limits and the read state encoding.
package rtc_pkg;

    localparam logic [7:0] ADDR_SEG  = 8'h00;
    localparam logic [7:0] ADDR_MIN  = 8'h01;
    localparam logic [7:0] ADDR_HORA = 8'h02;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

endpackage

// File: rtl/rtc_time_base.sv
// One-second tick divider and BCD seconds/minutes/hours increment. Updates are
// offered to the register file through upd and always yield to a host write.
module rtc_time_base
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_time_wr,
    input  logic [7:0] sec,
    input  logic [7:0] mins,
    input  logic [7:0] hrs,
    output logic       tick,
    output logic       upd,
    output logic [7:0] sec_nxt,
    output logic [7:0] mins_nxt,
    output logic [7:0] hrs_nxt
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick_pending;
    logic          due;
    logic          sec_wrap;
    logic          min_wrap;

    // Values that are not valid BCD simply count on in binary until they
    // happen to hit the roll-over compare.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
        return v + 8'h01;
    endfunction

    assign due = tick | tick_pending;
    assign upd = due & ~host_time_wr;

    always_comb begin
        sec_wrap = (sec == BCD_MAX_MS);
        min_wrap = sec_wrap && (mins == BCD_MAX_MS);
        sec_nxt  = sec_wrap ? 8'h00 : bcd_inc(sec);
        mins_nxt = mins;
        hrs_nxt  = hrs;
        if (sec_wrap) mins_nxt = (mins == BCD_MAX_MS) ? 8'h00 : bcd_inc(mins);
        if (min_wrap) hrs_nxt  = (hrs == BCD_MAX_HR) ? 8'h00 : bcd_inc(hrs);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            tick         <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // A host write to a time register defers the tick by one cycle;
            // a second tick arriving while one is pending stays queued.
            if (due && host_time_wr) tick_pending <= 1'b1;
            else if (upd)            tick_pending <= tick & tick_pending;
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Chip-side model of the RTC multiplexed address/data bus: strobe decode,
// 16-byte register file, read state machine and the running BCD time base.
module rtc_bus_responder
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int NREGS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       a_d,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       proto_err,
    output logic       tick
);

    localparam int AW = $clog2(NREGS);

    state_t     state;
    logic       rd_q;
    logic       wr_q;
    logic       illegal_q;
    logic [7:0] addr_reg;
    logic [7:0] regs [NREGS];

    logic       wr_rise;
    logic       rd_fall;
    logic       rd_rise;
    logic       illegal;
    logic       in_range;
    logic       latch_en;
    logic       reg_wr;
    logic       host_time_wr;
    logic [7:0] rd_data;
    logic       tb_upd;
    logic [7:0] sec_nxt;
    logic [7:0] mins_nxt;
    logic [7:0] hrs_nxt;

    assign wr_rise  = ~wr_q & wr;
    assign rd_fall  = rd_q & ~rd;
    assign rd_rise  = ~rd_q & rd;
    assign illegal  = ~cs & ~rd & ~wr;
    assign in_range = (addr_reg < 8'(NREGS));

    assign latch_en     = ~cs & ~a_d & wr_rise & ~illegal;
    assign reg_wr       = ~cs &  a_d & wr_rise & ~illegal & in_range;
    assign host_time_wr = reg_wr & (addr_reg <= ADDR_HORA);
    assign rd_data      = in_range ? regs[addr_reg[AW-1:0]] : 8'h00;

    rtc_time_base #(
        .TICK_DIV (TICK_DIV)
    ) u_time_base (
        .clk          (clk),
        .reset        (reset),
        .host_time_wr (host_time_wr),
        .sec          (regs[ADDR_SEG[AW-1:0]]),
        .mins         (regs[ADDR_MIN[AW-1:0]]),
        .hrs          (regs[ADDR_HORA[AW-1:0]]),
        .tick         (tick),
        .upd          (tb_upd),
        .sec_nxt      (sec_nxt),
        .mins_nxt     (mins_nxt),
        .hrs_nxt      (hrs_nxt)
    );

    // Host write comes last so it overrides any same-cycle time base update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
            if (tb_upd) begin
                regs[ADDR_SEG[AW-1:0]]  <= sec_nxt;
                regs[ADDR_MIN[AW-1:0]]  <= mins_nxt;
                regs[ADDR_HORA[AW-1:0]] <= hrs_nxt;
            end
            if (reg_wr) regs[addr_reg[AW-1:0]] <= ad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            illegal_q <= 1'b0;
            addr_reg  <= 8'h00;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rd_q      <= rd;
            wr_q      <= wr;
            illegal_q <= illegal;
            proto_err <= illegal & ~illegal_q;
            if (latch_en) addr_reg <= ad_in;
            if (illegal) begin
                state <= ST_IDLE;
                ad_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (~cs && a_d && rd_fall) begin
                            state  <= ST_READ;
                            ad_oe  <= 1'b1;
                            ad_out <= rd_data;
                        end
                    end
                    ST_READ: begin
                        // ad_out keeps the last read value after release.
                        if (cs || rd_rise) begin
                            state <= ST_IDLE;
                            ad_oe <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ad_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder with a short tick period; a behavioural
// register/time model predicts every read value.
module tb_rtc_bus_responder;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       a_d;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       proto_err;
    logic       tick;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q [$];

    // Reference model state
    logic [7:0] m_regs [16];
    int         m_cnt;
    bit         m_tick;
    bit         m_pend;
    bit         m_wr_now;
    logic [7:0] m_wr_addr;
    logic [7:0] m_wr_data;
    logic [7:0] m_addr;

    rtc_bus_responder #(.TICK_DIV(TD), .NREGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .a_d       (a_d),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .proto_err (proto_err),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_bcd(input logic [7:0] v);
        logic [7:0] r;
        r = v + 8'h01;
        if (v[3:0] == 4'h9) r = {v[7:4] + 4'h1, 4'h0};
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] s;
        logic [7:0] mi;
        logic [7:0] h;
        bit         host_time;
        bit         apply;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 8'h00;
            m_cnt  <= 0;
            m_tick <= 1'b0;
            m_pend <= 1'b0;
        end else begin
            s = m_regs[0]; mi = m_regs[1]; h = m_regs[2];
            host_time = m_wr_now && (m_wr_addr < 8'd3);
            apply     = m_tick || m_pend;
            if (apply && !host_time) begin
                if (s == 8'h59) begin
                    s = 8'h00;
                    if (mi == 8'h59) begin
                        mi = 8'h00;
                        h  = (h == 8'h23) ? 8'h00 : m_bcd(h);
                    end else begin
                        mi = m_bcd(mi);
                    end
                end else begin
                    s = m_bcd(s);
                end
                m_regs[0] <= s; m_regs[1] <= mi; m_regs[2] <= h;
                m_pend <= m_tick && m_pend;
            end else if (apply) begin
                m_pend <= 1'b1;
            end
            if (m_wr_now && m_wr_addr < 8'd16) m_regs[m_wr_addr[3:0]] <= m_wr_data;
            if (m_cnt == TD - 1) begin
                m_cnt  <= 0;
                m_tick <= 1'b1;
            end else begin
                m_cnt  <= m_cnt + 1;
                m_tick <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_latch(input logic [7:0] a);
        cs = 1'b0; a_d = 1'b0; ad_in = a; wr = 1'b0;
        step();
        wr = 1'b1;
        step();
        m_addr = a;
        cs = 1'b1;
    endtask

    task automatic bus_data(input logic [7:0] d);
        cs = 1'b0; a_d = 1'b1; ad_in = d; wr = 1'b0;
        step();
        wr = 1'b1;
        m_wr_now = 1'b1; m_wr_addr = m_addr; m_wr_data = d;
        step();
        m_wr_now = 1'b0;
        cs = 1'b1; a_d = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_latch(a);
        bus_data(d);
    endtask

    task automatic bus_read(input string name);
        logic [7:0] e;
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        exp_q.push_back((m_addr < 8'd16) ? m_regs[m_addr[3:0]] : 8'h00);
        compared++;
        if (ad_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL %s oe_before_detect: got %b want 0", name, ad_oe);
        end
        step();
        compared++;
        if (ad_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL %s oe_on: got %b want 1", name, ad_oe);
        end
        e = exp_q.pop_front();
        compared++;
        if (ad_out !== e) begin
            mismatched++;
            $display("FAIL %s data: got %h want %h", name, ad_out, e);
        end
        rd = 1'b1;
        step();
        compared++;
        if (ad_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL %s oe_off: got %b want 0", name, ad_oe);
        end
        cs = 1'b1;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        compared++;
        if (tick !== 1'b1) begin
            mismatched++;
            $display("FAIL %s tick_timeout: got %b want 1", name, tick);
        end
    endtask

    task automatic check_regs_vs_model(input string name);
        int bad = -1;
        for (int i = 0; i < 16; i++)
            if (dut.regs[i] !== m_regs[i] && bad < 0) bad = i;
        compared++;
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL %s reg%0d: got %h want %h", name, bad, dut.regs[bad], m_regs[bad]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; a_d = 1'b0; ad_in = 8'h00;
        m_wr_now = 1'b0; m_wr_addr = 8'h00; m_wr_data = 8'h00; m_addr = 8'h00;
        repeat (3) step();
        compared++;
        if ({ad_oe, proto_err, tick, ad_out} !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got oe=%b err=%b tick=%b out=%h want all 0",
                     ad_oe, proto_err, tick, ad_out);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        bus_write(8'h04, 8'h05);
        bus_read("rd_reg4");
        compared++;
        if (ad_out !== 8'h05) begin
            mismatched++;
            $display("FAIL out_hold: got %h want 05", ad_out);
        end
    endtask

    task automatic test_rollover();
        bus_write(8'h02, 8'h23);
        bus_write(8'h01, 8'h59);
        bus_write(8'h00, 8'h59);
        wait_tick("rollover");
        step();
        compared++;
        if (dut.regs[1] !== 8'h00 || dut.regs[2] !== 8'h00) begin
            mismatched++;
            $display("FAIL rollover_min_hr: got %h %h want 00 00", dut.regs[1], dut.regs[2]);
        end
        bus_latch(8'h00); bus_read("rd_sec");
        bus_latch(8'h01); bus_read("rd_min");
        bus_latch(8'h02); bus_read("rd_hr");
    endtask

    task automatic test_out_of_range();
        bus_latch(8'h20);
        bus_data(8'hAA);
        bus_read("rd_oor");
        check_regs_vs_model("oor_regs");
        bus_latch(8'h04);
        bus_read("rd_reg4_after_oor");
    endtask

    task automatic test_collision();
        bus_latch(8'h00);
        wait_tick("collide_sync");
        step(); step();
        cs = 1'b0; a_d = 1'b1; ad_in = 8'h30; wr = 1'b0;
        step(); step();
        compared++;
        if (tick !== 1'b1) begin
            mismatched++;
            $display("FAIL collide_tick_phase: got %b want 1", tick);
        end
        wr = 1'b1;
        m_wr_now = 1'b1; m_wr_addr = 8'h00; m_wr_data = 8'h30;
        step();
        m_wr_now = 1'b0;
        cs = 1'b1; a_d = 1'b0;
        compared++;
        if (dut.regs[0] !== 8'h30) begin
            mismatched++;
            $display("FAIL collide_write_wins: got %h want 30", dut.regs[0]);
        end
        step();
        compared++;
        if (dut.regs[0] !== 8'h31) begin
            mismatched++;
            $display("FAIL collide_pending: got %h want 31", dut.regs[0]);
        end
        repeat (3) step();
        compared++;
        if (dut.regs[0] !== 8'h32) begin
            mismatched++;
            $display("FAIL collide_next_tick: got %h want 32", dut.regs[0]);
        end
        bus_read("rd_sec_after_collide");
    endtask

    task automatic test_proto_err();
        logic [7:0] e;
        bus_latch(8'h04);
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        exp_q.push_back(m_regs[4]);
        step();
        e = exp_q.pop_front();
        compared++;
        if (ad_oe !== 1'b1 || ad_out !== e) begin
            mismatched++;
            $display("FAIL proto_pre_read: got oe=%b out=%h want 1 %h", ad_oe, ad_out, e);
        end
        wr = 1'b0;
        step();
        compared++;
        if (proto_err !== 1'b1 || ad_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL proto_pulse: got err=%b oe=%b want 1 0", proto_err, ad_oe);
        end
        step();
        compared++;
        if (proto_err !== 1'b0) begin
            mismatched++;
            $display("FAIL proto_one_cycle: got %b want 0", proto_err);
        end
        cs = 1'b1; rd = 1'b1; wr = 1'b1;
        step();
        check_regs_vs_model("proto_regs");
        bus_read("rd_after_proto");
    endtask

    task automatic test_reset_mid_read();
        int bad;
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        step();
        compared++;
        if (ad_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_read_start: got %b want 1", ad_oe);
        end
        reset = 1'b1; cs = 1'b1; rd = 1'b1;
        step();
        compared++;
        if (ad_oe !== 1'b0 || ad_out !== 8'h00) begin
            mismatched++;
            $display("FAIL rst_mid_read: got oe=%b out=%h want 0 00", ad_oe, ad_out);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (dut.regs[i] !== 8'h00 && bad < 0) bad = i;
        compared++;
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL rst_regs: reg%0d got %h want 00", bad, dut.regs[bad]);
        end
        m_addr = 8'h00;
        reset = 1'b0;
        for (int i = 1; i < TD; i++) begin
            step();
            compared++;
            if (tick !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_tick_early cycle%0d: got %b want 0", i, tick);
            end
        end
        step();
        compared++;
        if (tick !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_tick_first: got %b want 1", tick);
        end
        bus_read("rd_after_reset");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rollover();
        test_out_of_range();
        test_collision();
        test_proto_err();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
